// File: rtl/spu_cache_filler.sv
// Packs BEATS stream beats into one cache line and writes consecutive lines
// from a programmed base address; one job per start, ended by a done pulse.
module spu_cache_filler #(
    parameter int LINE_WIDTH = 1024,
    parameter int IN_WIDTH   = 128,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   num_lines_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  s_valid_i,
    input  logic [IN_WIDTH-1:0]   s_data_i,
    output logic                  s_ready_o,
    output logic                  cache_we_o,
    output logic [ADDR_WIDTH-1:0] cache_addr_o,
    output logic [LINE_WIDTH-1:0] cache_din_o
);
    localparam int BEATS = LINE_WIDTH / IN_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     num_q;
    logic [ADDR_WIDTH:0]     line_cnt_q;
    logic [BW-1:0]           beat_cnt_q;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic                    busy_q, done_q, s_ready_q, we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   din_q;

    // Line buffer with the current beat merged in; loaded into din_q on the
    // last beat so the write data is already registered when WRITE begins.
    always_comb begin
        line_d = line_q;
        line_d[beat_cnt_q*IN_WIDTH +: IN_WIDTH] = s_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            line_cnt_q <= '0;
            beat_cnt_q <= '0;
            line_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            s_ready_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (num_lines_i != '0) begin
                            base_q     <= base_addr_i;
                            num_q      <= num_lines_i;
                            line_cnt_q <= '0;
                            beat_cnt_q <= '0;
                            s_ready_q  <= 1'b1;
                            state_q    <= FILL;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                FILL: begin
                    if (s_valid_i) begin
                        line_q <= line_d;
                        if (beat_cnt_q == BW'(BEATS - 1)) begin
                            beat_cnt_q <= '0;
                            s_ready_q  <= 1'b0;
                            we_q       <= 1'b1;
                            addr_q     <= base_q + line_cnt_q[ADDR_WIDTH-1:0];
                            din_q      <= line_d;
                            state_q    <= WRITE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BW'(1);
                        end
                    end
                end
                WRITE: begin
                    if (line_cnt_q == num_q - (ADDR_WIDTH+1)'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        line_cnt_q <= line_cnt_q + (ADDR_WIDTH+1)'(1);
                        s_ready_q  <= 1'b1;
                        state_q    <= FILL;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign s_ready_o    = s_ready_q;
    assign cache_we_o   = we_q;
    assign cache_addr_o = addr_q;
    assign cache_din_o  = din_q;
endmodule

// File: tb/tb_spu_cache_filler.sv
// Scoreboard bench for spu_cache_filler: expected writes are queued as lines
// are streamed in and compared lane by lane when cache_we fires.
module tb_spu_cache_filler;
    localparam int LW = 1024, IW = 128, AW = 9, BEATS = 8;

    logic          clk = 0, rst_n = 0;
    logic          start_r = 0, noise_r = 0, noise_en = 0;
    logic          start;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_lines = '0;
    logic          s_valid = 0;
    logic [IW-1:0] s_data = '0;
    logic          busy, done, s_ready, cache_we;
    logic [AW-1:0] cache_addr;
    logic [LW-1:0] cache_din;

    assign start = start_r | noise_r;

    spu_cache_filler #(.LINE_WIDTH(LW), .IN_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .base_addr_i(base_addr),
        .num_lines_i(num_lines), .busy_o(busy), .done_o(done), .s_valid_i(s_valid),
        .s_data_i(s_data), .s_ready_o(s_ready), .cache_we_o(cache_we),
        .cache_addr_o(cache_addr), .cache_din_o(cache_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] din;
    } wr_t;
    wr_t sb[$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, writes = 0, dones = 0, last_we = 0, done_cyc = 0;
    int we_cyc[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) noise_r = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (cache_we) begin
                writes++;
                last_we = cyc;
                we_cyc.push_back(cyc);
                check("ready_in_write", 128'(s_ready), 128'(0));
                if (sb.size() == 0) check("unexpected_write", 128'(1), 128'(0));
                else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("addr", 128'(cache_addr), 128'(e.addr));
                    for (int k = 0; k < BEATS; k++)
                        check($sformatf("lane%0d", k), cache_din[k*IW +: IW], e.din[k*IW +: IW]);
                end
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic push_beat(input logic [IW-1:0] d, output bit ok);
        bit r;
        s_valid = 1;
        s_data  = d;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            r = s_ready;
            @(negedge clk);
            if (r) begin
                ok = 1;
                break;
            end
        end
        s_valid = 0;
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int num, input int gap,
                           input bit seq, input bit noise);
        int w0, d0;
        bit ok, seen;
        logic [LW-1:0] line;
        wr_t e;
        w0 = writes;
        d0 = dones;
        we_cyc.delete();
        base_addr = base;
        num_lines = (AW+1)'(num);
        start_r = 1;
        @(negedge clk);
        start_r = 0;
        base_addr = AW'($urandom);
        num_lines = (AW+1)'($urandom);
        noise_en = noise;
        check("busy_after_start", 128'(busy), 128'(1));
        for (int l = 0; l < num; l++) begin
            for (int k = 0; k < BEATS; k++)
                line[k*IW +: IW] = seq ? IW'(k + 1) : {$urandom, $urandom, $urandom, $urandom};
            e.addr = base + AW'(l);
            e.din  = line;
            sb.push_back(e);
            for (int k = 0; k < BEATS; k++) begin
                while (gap > 0 && $urandom_range(0, 99) < gap) @(negedge clk);
                push_beat(line[k*IW +: IW], ok);
                if (!ok) check("beat_timeout", 128'(0), 128'(1));
            end
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", 128'(seen), 128'(1));
        noise_en = 0;
        @(posedge clk);
        check("done_after_write", 128'(done_cyc - last_we), 128'(1));
        @(negedge clk);
        check("busy_low_after", 128'(busy), 128'(0));
        check("done_single", 128'(done), 128'(0));
        check("write_count", 128'(writes - w0), 128'(num));
        check("done_count", 128'(dones - d0), 128'(1));
        check("sb_empty", 128'(sb.size()), 128'(0));
        if (gap == 0)
            for (int i = 1; i < we_cyc.size(); i++)
                check("write_spacing", 128'(we_cyc[i] - we_cyc[i-1]), 128'(BEATS + 1));
    endtask

    initial begin
        bit ok;
        int w0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_ready", 128'(s_ready), 128'(0));
        check("rst_we", 128'({cache_we, done}), 128'(0));
        check("rst_din", 128'(|{cache_din, cache_addr}), 128'(0));
        rst_n = 1;
        @(negedge clk);

        // 1: single line, beat k carries k+1
        run_job(9'd0, 1, 0, 1, 0);
        // 2: address wrap 510, 511, 0
        run_job(9'd510, 3, 0, 0, 0);
        // 3: random valid gaps
        run_job(9'd40, 2, 50, 0, 0);

        // 4: zero-length job
        w0 = writes;
        num_lines = '0;
        base_addr = 9'd5;
        start_r = 1;
        @(negedge clk);
        start_r = 0;
        check("zero_done", 128'(done), 128'(1));
        check("zero_busy", 128'(busy), 128'(1));
        check("zero_ready", 128'(s_ready), 128'(0));
        @(negedge clk);
        check("zero_done_end", 128'({done, busy, s_ready}), 128'(0));
        check("zero_no_write", 128'(writes - w0), 128'(0));

        // 6: start noise during a job, then a fresh start is accepted
        run_job(9'd100, 2, 0, 0, 1);
        run_job(9'd20, 1, 0, 0, 0);

        // 5: reset in the middle of a line
        w0 = writes;
        base_addr = 9'd3;
        num_lines = 10'd1;
        start_r = 1;
        @(negedge clk);
        start_r = 0;
        for (int k = 0; k < 4; k++) begin
            push_beat({$urandom, $urandom, $urandom, $urandom}, ok);
            if (!ok) check("beat_timeout", 128'(0), 128'(1));
        end
        rst_n = 0;
        #1;
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_ready", 128'(s_ready), 128'(0));
        check("arst_we_done", 128'({cache_we, done}), 128'(0));
        check("arst_addr", 128'(cache_addr), 128'(0));
        check("arst_din", 128'(|cache_din), 128'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("arst_no_write", 128'(writes - w0), 128'(0));
        check("arst_idle_ready", 128'(s_ready), 128'(0));
        run_job(9'd7, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
